// File: rtl/wb_burst_pkg.sv
// Shared types and constants for the Wishbone burst-to-single-beat splitter.
// Holds the FSM encoding, the captured-request record and the address stride.
package wb_burst_pkg;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_BUSY     = 2'd1;
  localparam logic [1:0] ST_WAIT_BRY = 2'd2;
  localparam logic [1:0] ST_DONE     = 2'd3;

  localparam logic [31:0] ADR_INC = 32'd4;

  typedef struct packed {
    logic [31:0] adr;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] dat;
    logic [9:0]  remaining;
  } burst_req_t;

  // A zero-length burst still moves one beat.
  function automatic logic [9:0] norm_bl(input logic [9:0] bl);
    return (bl == 10'd0) ? 10'd1 : bl;
  endfunction

endpackage

// File: rtl/wb_burst_splitter_timeout.sv
// No-response watchdog for one downstream beat: counts while enabled and
// flags expiry on the cycle that would make the wait TIMEOUT_CYC long.
module wb_timeout_cnt #(
  parameter int TIMEOUT_CYC = 255,
  parameter int TO_W        = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic expire
);

  localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         cnt <= '0;
    else if (clear)  cnt <= '0;
    else if (enable) cnt <= cnt + 1'b1;
  end

  // Clear wins so an ack landing on the last cycle is never turned into an error.
  assign expire = enable & ~clear & (cnt == LAST);

endmodule

// File: rtl/wb_burst_splitter.sv
// Splits an upstream Wishbone burst into single-beat accesses to a non-burst
// slave, returning per-beat ack, last-ack and error (including a timeout).
module wb_burst_splitter
  import wb_burst_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255,
  parameter int TO_W        = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [9:0]  wbs_bl_i,
  input  logic        wbs_bry_i,
  input  logic        wbs_we_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic        wbs_lack_o,
  output logic        wbs_err_o,
  output logic [31:0] wbd_dat_o,
  output logic [31:0] wbd_adr_o,
  output logic [3:0]  wbd_sel_o,
  output logic        wbd_we_o,
  output logic        wbd_cyc_o,
  output logic        wbd_stb_o,
  input  logic [31:0] wbd_dat_i,
  input  logic        wbd_ack_i,
  input  logic        wbd_err_i
);

  logic [1:0] state;
  burst_req_t req;
  logic       dn_stb;
  logic       to_en;
  logic       to_clr;
  logic       to_expire;

  assign to_en  = (state == ST_BUSY);
  assign to_clr = (state != ST_BUSY) | wbd_ack_i | wbd_err_i;

  wb_timeout_cnt #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .TO_W        (TO_W)
  ) u_timeout (
    .clk    (clk_i),
    .rst    (rst_i),
    .enable (to_en),
    .clear  (to_clr),
    .expire (to_expire)
  );

  // Downstream outputs come straight from the captured-request registers.
  assign wbd_dat_o = req.dat;
  assign wbd_adr_o = req.adr;
  assign wbd_sel_o = req.sel;
  assign wbd_we_o  = req.we;
  assign wbd_cyc_o = dn_stb;
  assign wbd_stb_o = dn_stb;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      req        <= '0;
      dn_stb     <= 1'b0;
      wbs_dat_o  <= '0;
      wbs_ack_o  <= 1'b0;
      wbs_lack_o <= 1'b0;
      wbs_err_o  <= 1'b0;
    end else begin
      wbs_ack_o  <= 1'b0;
      wbs_lack_o <= 1'b0;
      wbs_err_o  <= 1'b0;
      wbs_dat_o  <= '0;
      case (state)
        ST_IDLE: begin
          if (wbs_cyc_i & wbs_stb_i & wbs_bry_i) begin
            req.adr       <= {wbs_adr_i[31:2], 2'b00};
            req.sel       <= wbs_sel_i;
            req.we        <= wbs_we_i;
            req.dat       <= wbs_dat_i;
            req.remaining <= norm_bl(wbs_bl_i);
            dn_stb        <= 1'b1;
            state         <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // Error (or a silent slave) beats a simultaneous ack and ends the burst.
          if (wbd_err_i | to_expire) begin
            wbs_err_o  <= 1'b1;
            wbs_lack_o <= 1'b1;
            dn_stb     <= 1'b0;
            state      <= ST_DONE;
          end else if (wbd_ack_i) begin
            wbs_ack_o <= 1'b1;
            wbs_dat_o <= req.we ? 32'd0 : wbd_dat_i;
            dn_stb    <= 1'b0;
            if (req.remaining == 10'd1) begin
              wbs_lack_o <= 1'b1;
              state      <= ST_DONE;
            end else begin
              req.remaining <= req.remaining - 10'd1;
              req.adr       <= req.adr + ADR_INC;
              state         <= ST_WAIT_BRY;
            end
          end
        end
        ST_WAIT_BRY: begin
          if (!wbs_stb_i) begin
            state <= ST_IDLE;
          end else if (wbs_bry_i) begin
            if (req.we) req.dat <= wbs_dat_i;
            dn_stb <= 1'b1;
            state  <= ST_BUSY;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_burst_splitter.sv
// Randomised and directed bench: acts as upstream master and downstream slave,
// logs what the splitter does, and compares against a transaction-level model.
module tb_wb_burst_splitter;

  localparam int TO_CYC = 8;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] wbs_dat_i = '0;
  logic [31:0] wbs_adr_i = '0;
  logic [3:0]  wbs_sel_i = '0;
  logic [9:0]  wbs_bl_i = '0;
  logic        wbs_bry_i = 1'b0;
  logic        wbs_we_i = 1'b0;
  logic        wbs_cyc_i = 1'b0;
  logic        wbs_stb_i = 1'b0;
  logic [31:0] wbs_dat_o;
  logic        wbs_ack_o, wbs_lack_o, wbs_err_o;
  logic [31:0] wbd_dat_o, wbd_adr_o;
  logic [3:0]  wbd_sel_o;
  logic        wbd_we_o, wbd_cyc_o, wbd_stb_o;
  logic [31:0] wbd_dat_i = '0;
  logic        wbd_ack_i = 1'b0;
  logic        wbd_err_i = 1'b0;

  always #5 clk_i = ~clk_i;

  wb_burst_splitter #(.TIMEOUT_CYC(TO_CYC), .TO_W(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .wbs_dat_i(wbs_dat_i), .wbs_adr_i(wbs_adr_i), .wbs_sel_i(wbs_sel_i), .wbs_bl_i(wbs_bl_i),
    .wbs_bry_i(wbs_bry_i), .wbs_we_i(wbs_we_i), .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i),
    .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o), .wbs_lack_o(wbs_lack_o), .wbs_err_o(wbs_err_o),
    .wbd_dat_o(wbd_dat_o), .wbd_adr_o(wbd_adr_o), .wbd_sel_o(wbd_sel_o), .wbd_we_o(wbd_we_o),
    .wbd_cyc_o(wbd_cyc_o), .wbd_stb_o(wbd_stb_o),
    .wbd_dat_i(wbd_dat_i), .wbd_ack_i(wbd_ack_i), .wbd_err_i(wbd_err_i)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int fixed_rd = 0;

  // Observation logs (per downstream beat / per upstream response) and stimulus logs.
  logic [31:0] o_adr[$], o_wdat[$], o_rdat[$], s_wdat[$], s_rdat[$];
  logic [3:0]  o_sel[$];
  logic        o_we[$], o_cyc[$], o_ack[$], o_lack[$], o_err[$], o_stb[$];
  int          o_lat[$];
  int          o_stall_stb, o_post, o_to_lat, o_abort;
  logic        o_rst_out;

  task automatic run_burst(input logic [31:0] adr, input int bl, input logic we, input logic [3:0] sel,
                           input int stall_beat, input int stall_len, input int err_beat,
                           input int hang_beat, input int rst_beat, input int ack_dly, input int tail);
    int nb, beat, phase, lat, dly, stall, hang_cnt;
    logic resp;
    logic [31:0] d;
    nb = (bl == 0) ? 1 : bl;
    o_adr.delete(); o_wdat.delete(); o_rdat.delete(); s_wdat.delete(); s_rdat.delete();
    o_sel.delete(); o_we.delete(); o_cyc.delete(); o_ack.delete(); o_lack.delete();
    o_err.delete(); o_stb.delete(); o_lat.delete();
    o_stall_stb = 0; o_post = 0; o_to_lat = -1; o_abort = 0; o_rst_out = 1'b0;
    beat = 0; phase = 0; lat = 0; dly = 0; stall = 0; hang_cnt = 0;
    @(negedge clk_i);
    d = $urandom; s_wdat.push_back(d);
    wbs_adr_i = adr; wbs_bl_i = 10'(bl); wbs_we_i = we; wbs_sel_i = sel; wbs_dat_i = d;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_bry_i = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk_i);
      resp = 1'b0;
      if (phase == 2) begin
        wbd_ack_i = 1'b0; wbd_err_i = 1'b0; resp = 1'b1;
      end else if (phase == 3) begin
        if (wbd_stb_o) o_stall_stb++;
        stall--;
        if (stall == 0) begin
          wbs_bry_i = 1'b1; wbs_dat_i = s_wdat[beat]; phase = 0; lat = 0;
        end
      end else if (phase == 4) begin
        hang_cnt++;
        if (wbs_err_o) begin o_to_lat = hang_cnt; resp = 1'b1; end
        else if (!wbd_stb_o) o_abort++;
      end else begin
        if (phase == 0) begin
          lat++;
          if (wbd_stb_o) begin
            o_lat.push_back(lat); o_adr.push_back(wbd_adr_o); o_wdat.push_back(wbd_dat_o);
            o_we.push_back(wbd_we_o); o_sel.push_back(wbd_sel_o); o_cyc.push_back(wbd_cyc_o);
            if (beat == rst_beat) begin
              rst_i = 1'b1;
              #1;
              o_rst_out = |{wbs_dat_o, wbs_ack_o, wbs_lack_o, wbs_err_o, wbd_dat_o, wbd_adr_o,
                            wbd_sel_o, wbd_we_o, wbd_cyc_o, wbd_stb_o};
              wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_bry_i = 1'b0;
              @(negedge clk_i);
              rst_i = 1'b0;
              return;
            end
            dly = ack_dly; hang_cnt = 0;
            phase = (beat == hang_beat) ? 4 : 1;
          end
        end
        if (phase == 1) begin
          if (!wbd_stb_o) o_abort++;
          if (dly == 0) begin
            d = (fixed_rd != 0) ? 32'h11 * 32'(beat + 1) : $urandom;
            s_rdat.push_back(d);
            wbd_dat_i = d; wbd_ack_i = 1'b1; wbd_err_i = (beat == err_beat); phase = 2;
          end else dly--;
        end
      end
      if (resp) begin
        o_ack.push_back(wbs_ack_o); o_lack.push_back(wbs_lack_o); o_err.push_back(wbs_err_o);
        o_rdat.push_back(wbs_dat_o); o_stb.push_back(wbd_stb_o);
        if (wbs_lack_o || wbs_err_o || beat == nb - 1) begin
          wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_bry_i = 1'b0;
          for (int t = 0; t < tail; t++) begin
            @(negedge clk_i);
            if (wbd_stb_o || wbs_ack_o || wbs_lack_o || wbs_err_o) o_post++;
          end
          return;
        end
        beat++;
        d = $urandom; s_wdat.push_back(d);
        if (beat - 1 == stall_beat && stall_len > 0) begin
          wbs_bry_i = 1'b0; wbs_dat_i = ~d; stall = stall_len; phase = 3;
        end else begin
          wbs_dat_i = d; phase = 0; lat = 0;
        end
      end
    end
    o_abort++;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_bry_i = 1'b0; wbd_ack_i = 1'b0; wbd_err_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    n_cmp++;
    if ({wbd_cyc_o, wbd_stb_o, wbs_ack_o, wbs_lack_o, wbs_err_o} !== 5'b0) begin
      n_bad++; $display("FAIL reset_strobes: got %b want 00000", {wbd_cyc_o, wbd_stb_o, wbs_ack_o, wbs_lack_o, wbs_err_o});
    end
    n_cmp++;
    if ({wbd_adr_o, wbd_dat_o, wbd_sel_o, wbd_we_o} !== 69'd0) begin
      n_bad++; $display("FAIL reset_dn_bus: adr %h dat %h want 0", wbd_adr_o, wbd_dat_o);
    end
    n_cmp++;
    if (wbs_dat_o !== 32'd0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", wbs_dat_o); end
    rst_i = 1'b0;
    @(negedge clk_i);
    n_cmp++;
    if (wbd_stb_o !== 1'b0) begin n_bad++; $display("FAIL reset_idle_stb: got %b want 0", wbd_stb_o); end
  endtask

  task automatic test_single_write();
    run_burst(32'h1000_0006, 1, 1'b1, 4'hF, -1, 0, -1, -1, -1, 2, 0);
    n_cmp++;
    if (o_adr.size() != 1 || o_adr[0] !== 32'h1000_0004) begin
      n_bad++; $display("FAIL single_adr: got %h (%0d beats) want 10000004 (1 beat)", o_adr[0], o_adr.size());
    end
    n_cmp++;
    if ({o_we[0], o_sel[0], o_cyc[0], o_wdat[0]} !== {1'b1, 4'hF, 1'b1, s_wdat[0]}) begin
      n_bad++; $display("FAIL single_wdat: got %h want %h", o_wdat[0], s_wdat[0]);
    end
    n_cmp++;
    if (o_lat[0] !== 1) begin n_bad++; $display("FAIL single_latency: got %0d want 1", o_lat[0]); end
    n_cmp++;
    if ({o_ack[0], o_lack[0], o_err[0], o_stb[0], o_rdat[0]} !== {4'b1100, 32'd0}) begin
      n_bad++; $display("FAIL single_resp: got ack%b lack%b err%b stb%b dat %h want 1100/0",
                        o_ack[0], o_lack[0], o_err[0], o_stb[0], o_rdat[0]);
    end
    // Presented immediately after lack: accepted one cycle later only if DONE was a single cycle.
    run_burst(32'h1000_0010, 1, 1'b0, 4'h3, -1, 0, -1, -1, -1, 0, 3);
    n_cmp++;
    if (o_lat.size() != 1 || o_lat[0] !== 1) begin
      n_bad++; $display("FAIL done_one_cycle: got latency %0d want 1", o_lat[0]);
    end
    n_cmp++;
    if ({o_ack[0], o_lack[0], o_rdat[0]} !== {2'b11, s_rdat[0]} || o_post != 0) begin
      n_bad++; $display("FAIL b2b_read: got %h post %0d want %h post 0", o_rdat[0], o_post, s_rdat[0]);
    end
  endtask

  task automatic test_read_burst();
    fixed_rd = 1;
    run_burst(32'h2000_0000, 4, 1'b0, 4'hF, -1, 0, -1, -1, -1, 1, 2);
    fixed_rd = 0;
    n_cmp++;
    if (o_adr.size() != 4 || o_ack.size() != 4) begin
      n_bad++; $display("FAIL read_count: got %0d beats %0d resps want 4", o_adr.size(), o_ack.size());
    end
    for (int i = 0; i < 4 && i < o_ack.size(); i++) begin
      n_cmp++;
      if ({o_adr[i], o_ack[i], o_lack[i], o_err[i], o_rdat[i]} !==
          {32'h2000_0000 + 32'(4 * i), 1'b1, (i == 3), 1'b0, 32'h11 * 32'(i + 1)}) begin
        n_bad++; $display("FAIL read_beat%0d: got adr %h dat %h lack %b want adr %h dat %h lack %b",
                          i, o_adr[i], o_rdat[i], o_lack[i], 32'h2000_0000 + 32'(4 * i), 32'h11 * 32'(i + 1), (i == 3));
      end
    end
  endtask

  task automatic test_bry_stall();
    run_burst(32'h0000_0100, 3, 1'b1, 4'h5, 0, 5, -1, -1, -1, 1, 2);
    n_cmp++;
    if (o_stall_stb != 0) begin n_bad++; $display("FAIL stall_stb: got %0d stb cycles want 0", o_stall_stb); end
    n_cmp++;
    if (o_lat.size() != 3 || o_lat[1] !== 1) begin
      n_bad++; $display("FAIL stall_resume_lat: got %0d want 1", o_lat[1]);
    end
    n_cmp++;
    if (o_wdat[1] !== s_wdat[1] || o_wdat[2] !== s_wdat[2]) begin
      n_bad++; $display("FAIL stall_wdat: got %h %h want %h %h", o_wdat[1], o_wdat[2], s_wdat[1], s_wdat[2]);
    end
    n_cmp++;
    if ({o_lack[0], o_lack[1], o_lack[2], o_adr[2]} !== {3'b001, 32'h0000_0108}) begin
      n_bad++; $display("FAIL stall_lack_adr: got lack %b%b%b adr %h want 001 00000108",
                        o_lack[0], o_lack[1], o_lack[2], o_adr[2]);
    end
  endtask

  task automatic test_error();
    run_burst(32'h5000_0000, 4, 1'b0, 4'hF, -1, 0, 1, -1, -1, 1, 4);
    n_cmp++;
    if (o_adr.size() != 2 || o_post != 0) begin
      n_bad++; $display("FAIL err_beats: got %0d issued post %0d want 2 and 0", o_adr.size(), o_post);
    end
    n_cmp++;
    if ({o_ack[0], o_lack[0], o_err[0]} !== 3'b100) begin
      n_bad++; $display("FAIL err_beat1: got %b%b%b want 100", o_ack[0], o_lack[0], o_err[0]);
    end
    n_cmp++;
    if ({o_ack[1], o_lack[1], o_err[1], o_stb[1], o_rdat[1]} !== {4'b0110, 32'd0}) begin
      n_bad++; $display("FAIL err_beat2: got ack%b lack%b err%b stb%b dat %h want 0110/0",
                        o_ack[1], o_lack[1], o_err[1], o_stb[1], o_rdat[1]);
    end
  endtask

  task automatic test_timeout();
    run_burst(32'h6000_0040, 2, 1'b1, 4'hC, -1, 0, -1, 0, -1, 0, 2);
    n_cmp++;
    if (o_to_lat != TO_CYC) begin n_bad++; $display("FAIL timeout_lat: got %0d want %0d", o_to_lat, TO_CYC); end
    n_cmp++;
    if ({o_ack[0], o_lack[0], o_err[0], o_stb[0]} !== 4'b0110 || o_post != 0 || o_abort != 0) begin
      n_bad++; $display("FAIL timeout_resp: got ack%b lack%b err%b stb%b post %0d abort %0d want 0110/0/0",
                        o_ack[0], o_lack[0], o_err[0], o_stb[0], o_post, o_abort);
    end
    run_burst(32'h6000_0080, 1, 1'b1, 4'hF, -1, 0, -1, -1, -1, 1, 0);
    n_cmp++;
    if (o_lat.size() != 1 || o_lat[0] !== 1 || {o_ack[0], o_lack[0]} !== 2'b11) begin
      n_bad++; $display("FAIL timeout_recover: got lat %0d ack%b lack%b want 1/11", o_lat[0], o_ack[0], o_lack[0]);
    end
  endtask

  task automatic test_reset_bl0_wrap();
    run_burst(32'h3000_0000, 4, 1'b1, 4'hF, -1, 0, -1, -1, 1, 1, 0);
    n_cmp++;
    if (o_rst_out !== 1'b0) begin n_bad++; $display("FAIL midburst_reset_outputs: got %b want 0", o_rst_out); end
    n_cmp++;
    if (o_adr.size() != 2 || o_ack.size() != 1) begin
      n_bad++; $display("FAIL midburst_reset_beats: got %0d issued %0d acked want 2/1", o_adr.size(), o_ack.size());
    end
    @(negedge clk_i);
    n_cmp++;
    if ({wbd_stb_o, wbs_ack_o, wbs_lack_o} !== 3'b000) begin
      n_bad++; $display("FAIL post_reset_quiet: got %b want 000", {wbd_stb_o, wbs_ack_o, wbs_lack_o});
    end
    run_burst(32'h4000_0008, 0, 1'b1, 4'h1, -1, 0, -1, -1, -1, 1, 3);
    n_cmp++;
    if (o_adr.size() != 1 || {o_ack[0], o_lack[0], o_err[0]} !== 3'b110 || o_post != 0) begin
      n_bad++; $display("FAIL bl0_one_beat: got %0d beats ack%b lack%b post %0d want 1/11/0",
                        o_adr.size(), o_ack[0], o_lack[0], o_post);
    end
    run_burst(32'hFFFF_FFFC, 2, 1'b0, 4'hF, -1, 0, -1, -1, -1, 0, 2);
    n_cmp++;
    if (o_adr.size() != 2 || o_adr[0] !== 32'hFFFF_FFFC || o_adr[1] !== 32'h0000_0000) begin
      n_bad++; $display("FAIL adr_wrap: got %h %h want fffffffc 00000000", o_adr[0], o_adr[1]);
    end
    n_cmp++;
    if ({o_rdat[1], o_lack[1]} !== {s_rdat[1], 1'b1}) begin
      n_bad++; $display("FAIL wrap_rdata: got %h lack %b want %h lack 1", o_rdat[1], o_lack[1], s_rdat[1]);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, ea, edat;
    logic        we, eerr, elack;
    logic [3:0]  sel;
    int          bl, nb, sb, eb, issued;
    for (int k = 0; k < 12; k++) begin
      a = $urandom;
      if (k % 4 == 3) a = 32'hFFFF_FFF0 | ($urandom & 32'hF);
      bl = $urandom_range(0, 5); nb = (bl == 0) ? 1 : bl;
      we = 1'($urandom); sel = 4'($urandom);
      sb = ($urandom_range(0, 1) == 1 && nb > 1) ? $urandom_range(0, nb - 2) : -1;
      eb = ($urandom_range(0, 3) == 0) ? $urandom_range(0, nb - 1) : -1;
      run_burst(a, bl, we, sel, sb, $urandom_range(1, 4), eb, -1, -1, $urandom_range(0, 3), (k % 2) * 2);
      issued = (eb >= 0) ? eb + 1 : nb;
      n_cmp++;
      if (o_adr.size() != issued || o_ack.size() != issued) begin
        n_bad++; $display("FAIL rnd%0d_count: got %0d issued %0d resp want %0d", k, o_adr.size(), o_ack.size(), issued);
      end
      for (int i = 0; i < issued && i < o_ack.size() && i < o_adr.size(); i++) begin
        ea = {a[31:2], 2'b00} + 32'(4 * i);
        n_cmp++;
        if ({o_adr[i], o_we[i], o_sel[i], o_cyc[i], (o_lat[i] == 1)} !== {ea, we, sel, 1'b1, 1'b1}) begin
          n_bad++; $display("FAIL rnd%0d_beat%0d_req: got adr %h we %b sel %h lat %0d want %h %b %h 1",
                            k, i, o_adr[i], o_we[i], o_sel[i], o_lat[i], ea, we, sel);
        end
        if (we) begin
          n_cmp++;
          if (o_wdat[i] !== s_wdat[i]) begin
            n_bad++; $display("FAIL rnd%0d_beat%0d_wdat: got %h want %h", k, i, o_wdat[i], s_wdat[i]);
          end
        end
        eerr  = (i == eb);
        elack = eerr || (i == nb - 1);
        edat  = (eerr || we) ? 32'd0 : s_rdat[i];
        n_cmp++;
        if ({o_ack[i], o_lack[i], o_err[i], o_stb[i], o_rdat[i]} !== {~eerr, elack, eerr, 1'b0, edat}) begin
          n_bad++; $display("FAIL rnd%0d_beat%0d_resp: got ack%b lack%b err%b stb%b dat %h want %b%b%b0 %h",
                            k, i, o_ack[i], o_lack[i], o_err[i], o_stb[i], o_rdat[i], ~eerr, elack, eerr, edat);
        end
      end
      n_cmp++;
      if (o_stall_stb != 0 || o_post != 0 || o_abort != 0) begin
        n_bad++; $display("FAIL rnd%0d_protocol: got stall_stb %0d post %0d abort %0d want 0 0 0",
                          k, o_stall_stb, o_post, o_abort);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read_burst();
    test_bry_stall();
    test_error();
    test_timeout();
    test_reset_bl0_wrap();
    test_random();
    repeat (2) @(negedge clk_i);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
